// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, FSM state encoding and iteration-counter sizing.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply (LSB first) and restoring
// divide (MSB first) sharing a hi/lo register pair over unsigned magnitudes.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] b_reg;
  logic            div_reg;

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    addend  = lo_reg[0] ? b_reg : '0;
    sum     = {1'b0, hi_reg} + {1'b0, addend};
    shifted = {hi_reg, lo_reg[XLEN-1]};
    diff    = shifted - {1'b0, b_reg};
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (div_reg) begin
      // diff[XLEN] set means the trial subtraction went negative: restore
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_reg[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hi_reg  <= '0;
      lo_reg  <= a;
      b_reg   <= b;
      div_reg <= is_div;
    end else if (step) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M-style multiply/divide execution unit: FSM, sign handling, divide
// fast paths (zero divisor, signed overflow) and a quotient/remainder reuse entry.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      w_addr_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            done_o,
  output logic            w_enable_o,
  output logic [4:0]      w_addr_o,
  output logic [XLEN-1:0] w_data_o,
  output logic            stall_req_o
);

  localparam int CNT_W = cnt_width(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_reg, state_next;

  op_e             op_reg;
  logic [4:0]      waddr_reg;
  logic [XLEN-1:0] result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic            q_neg_reg;
  logic            r_neg_reg;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] rs2_reg;
  logic            signed_reg;

  logic            reuse_valid_reg;
  logic [XLEN-1:0] reuse_a_reg;
  logic [XLEN-1:0] reuse_b_reg;
  logic            reuse_signed_reg;
  logic [XLEN-1:0] reuse_q_reg;
  logic [XLEN-1:0] reuse_r_reg;

  // Request decode
  op_e             op_in;
  logic            in_div, in_rem, in_div_signed, sign_a, sign_b, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, reuse_hit, fast, accept, last_step;
  logic [XLEN-1:0] fast_result;

  assign op_in         = op_e'(op_i);
  assign in_div        = op_i[2];
  assign in_rem        = op_i[2] & op_i[1];
  assign in_div_signed = op_i[2] & ~op_i[0];
  assign sign_a        = in_div_signed | (op_in == OP_MULH) | (op_in == OP_MULHSU);
  assign sign_b        = in_div_signed | (op_in == OP_MULH);
  assign a_neg         = sign_a & rs1_i[XLEN-1];
  assign b_neg         = sign_b & rs2_i[XLEN-1];
  assign mag_a         = a_neg ? -rs1_i : rs1_i;
  assign mag_b         = b_neg ? -rs2_i : rs2_i;

  assign div_zero  = in_div & (rs2_i == '0);
  assign div_ovf   = in_div_signed & (rs1_i == MIN_NEG) & (rs2_i == '1);
  assign reuse_hit = REUSE_EN & reuse_valid_reg & in_div & (rs1_i == reuse_a_reg)
                   & (rs2_i == reuse_b_reg) & (in_div_signed == reuse_signed_reg);
  assign fast      = div_zero | div_ovf | reuse_hit;
  assign accept    = (state_reg == S_IDLE) & valid_i & ~flush_i;
  assign last_step = (state_reg == S_CALC) & (cnt_reg == CNT_W'(XLEN - 1));

  always_comb begin
    fast_result = '0;
    if (div_zero)
      fast_result = in_rem ? rs1_i : '1;
    else if (div_ovf)
      fast_result = in_rem ? '0 : rs1_i;
    else
      fast_result = in_rem ? reuse_r_reg : reuse_q_reg;
  end

  logic [XLEN-1:0] hi_next, lo_next;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .load    (accept),
    .step    (state_reg == S_CALC),
    .is_div  (in_div),
    .a       (mag_a),
    .b       (mag_b),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Sign fix-up applied to the final iteration's output as it is captured
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, calc_result;

  always_comb begin
    prod_fix    = q_neg_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
    q_fix       = q_neg_reg ? -lo_next : lo_next;
    r_fix       = r_neg_reg ? -hi_next : hi_next;
    calc_result = '0;
    if (op_reg[2])
      calc_result = op_reg[1] ? r_fix : q_fix;
    else if (op_reg == OP_MUL)
      calc_result = prod_fix[XLEN-1:0];
    else
      calc_result = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = fast ? S_DONE : S_CALC;
      S_CALC:  if (flush_i) state_next = S_IDLE;
               else if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg           <= OP_MUL;
      waddr_reg        <= '0;
      result_reg       <= '0;
      cnt_reg          <= '0;
      q_neg_reg        <= 1'b0;
      r_neg_reg        <= 1'b0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      signed_reg       <= 1'b0;
      reuse_valid_reg  <= 1'b0;
      reuse_a_reg      <= '0;
      reuse_b_reg      <= '0;
      reuse_signed_reg <= 1'b0;
      reuse_q_reg      <= '0;
      reuse_r_reg      <= '0;
    end else begin
      if (accept) begin
        op_reg     <= op_in;
        waddr_reg  <= w_addr_i;
        q_neg_reg  <= a_neg ^ b_neg;
        r_neg_reg  <= a_neg;
        rs1_reg    <= rs1_i;
        rs2_reg    <= rs2_i;
        signed_reg <= in_div_signed;
        cnt_reg    <= '0;
        if (fast) result_reg <= fast_result;
      end
      if (state_reg == S_CALC) cnt_reg <= cnt_reg + CNT_W'(1);
      if (last_step && !flush_i) begin
        result_reg <= calc_result;
        if (op_reg[2]) begin
          reuse_valid_reg  <= REUSE_EN;
          reuse_a_reg      <= rs1_reg;
          reuse_b_reg      <= rs2_reg;
          reuse_signed_reg <= signed_reg;
          reuse_q_reg      <= q_fix;
          reuse_r_reg      <= r_fix;
        end else begin
          reuse_valid_reg <= 1'b0;
        end
      end
      if (flush_i) reuse_valid_reg <= 1'b0;
    end
  end

  // A flush coinciding with the result strobe drops the write-back entirely
  assign ready_o     = (state_reg == S_IDLE);
  assign done_o      = (state_reg == S_DONE) & ~flush_i;
  assign w_enable_o  = done_o & (waddr_reg != 5'd0);
  assign w_addr_o    = w_enable_o ? waddr_reg : 5'd0;
  assign w_data_o    = w_enable_o ? result_reg : '0;
  assign stall_req_o = (valid_i & (state_reg == S_IDLE)) | (state_reg == S_CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv (XLEN=32): stimulus pushes expected
// write-backs into a queue, a monitor pops and checks each done_o strobe.
module tb_ex_muldiv;

  localparam int K_NORM = 0, K_STALL = 1, K_FLUSH = 2, K_RST = 3, K_FIDLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic [4:0]  w_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, done_o, w_enable_o, stall_req_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          kind;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wen;
    int          lat;
    int          c0;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  ex_muldiv #(.XLEN(32), .REUSE_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .w_addr_i    (w_addr_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .w_enable_o  (w_enable_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done_o=1 addr=%0d data=%h, expected none", w_addr_o, w_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("done addr=%0d wen=%0d data=%h latency=%0d", w_addr_o, w_enable_o, w_data_o, cyc - e.c0);
        chk("w_data", 64'(w_data_o), 64'(e.data));
        chk("w_addr", 64'(w_addr_o), 64'(e.addr));
        chk("w_enable", 64'(w_enable_o), 64'(e.wen));
        chk("latency", 64'(cyc - e.c0), 64'(e.lat));
      end
    end
  end

  task automatic add(input int kind, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] wa, input logic [31:0] exp,
                     input int lat);
    vec_t v;
    v.kind = kind; v.op = op; v.a = a; v.b = b; v.wa = wa; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic run(input vec_t v);
    int   c0;
    exp_t e;
    @(posedge clk); #1;
    for (int k = 0; k < 100 && ready_o !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    valid_i  = 1'b1;
    op_i     = v.op;
    rs1_i    = v.a;
    rs2_i    = v.b;
    w_addr_i = v.wa;
    c0       = cyc;
    if (v.kind == K_FIDLE) begin
      flush_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_idle_ready", 64'(ready_o), 64'd1);
      repeat (40) @(posedge clk);
      return;
    end
    if (v.kind == K_NORM || v.kind == K_STALL) begin
      e.data = (v.wa == 5'd0) ? 32'd0 : v.exp;
      e.addr = v.wa;
      e.wen  = (v.wa != 5'd0);
      e.lat  = v.lat;
      e.c0   = c0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (v.kind == K_STALL) chk("stall_c0", 64'(stall_req_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (v.kind == K_FLUSH || v.kind == K_RST) begin
      while (cyc < c0 + ((v.kind == K_FLUSH) ? 10 : 20)) begin
        @(posedge clk); #1;
      end
      if (v.kind == K_FLUSH) flush_i = 1'b1;
      else                   rst = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      chk("abort_ready", 64'(ready_o), 64'd1);
      chk("abort_done", 64'(done_o), 64'd0);
      chk("abort_wen", 64'(w_enable_o), 64'd0);
      chk("abort_waddr", 64'(w_addr_o), 64'd0);
      chk("abort_wdata", 64'(w_data_o), 64'd0);
      repeat (40) @(posedge clk);
      return;
    end
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      if (v.kind == K_STALL) chk("stall", 64'(stall_req_o), 64'((cyc - c0) <= 32));
      #1;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got no done_o within 200 cycles, expected latency %0d", v.lat);
      exp_q.delete();
    end
  endtask

  initial begin
    // kind, op, rs1, rs2, waddr, expected, latency
    add(K_STALL, 3'd0, 32'd7,          32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33); // MUL
    add(K_NORM,  3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33); // MULHU
    add(K_NORM,  3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'h00000000, 33); // MULH
    add(K_NORM,  3'd2, 32'hFFFFFFFF,   32'd2,        5'd4,  32'hFFFFFFFF, 33); // MULHSU
    add(K_NORM,  3'd4, 32'd100,        32'd0,        5'd5,  32'hFFFFFFFF, 1);  // DIV /0
    add(K_NORM,  3'd6, 32'd100,        32'd0,        5'd6,  32'd100,      1);  // REM /0
    add(K_NORM,  3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd7,  32'h80000000, 1);  // DIV ovf
    add(K_NORM,  3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd8,  32'd0,        1);  // REM ovf
    add(K_NORM,  3'd4, 32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 33); // DIV -7/2
    add(K_NORM,  3'd6, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 1);  // REM reuse
    add(K_NORM,  3'd0, 32'd3,          32'd4,        5'd11, 32'd12,       33); // MUL kills reuse
    add(K_NORM,  3'd6, 32'hFFFFFFF9,   32'd2,        5'd12, 32'hFFFFFFFF, 33);
    add(K_NORM,  3'd5, 32'd100,        32'd7,        5'd13, 32'd14,       33); // DIVU
    add(K_NORM,  3'd7, 32'd100,        32'd7,        5'd14, 32'd2,        1);  // REMU reuse
    add(K_NORM,  3'd6, 32'd100,        32'd7,        5'd15, 32'd2,        33); // signedness differs
    add(K_NORM,  3'd4, 32'd7,          32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 33); // DIV 7/-2
    add(K_NORM,  3'd6, 32'd7,          32'hFFFFFFFE, 5'd17, 32'd1,        1);
    add(K_NORM,  3'd0, 32'd5,          32'd6,        5'd0,  32'd30,       33); // x0 destination
    add(K_FIDLE, 3'd5, 32'd100,        32'd3,        5'd18, 32'd0,        0);
    add(K_NORM,  3'd5, 32'd100,        32'd7,        5'd19, 32'd14,       33);
    add(K_FLUSH, 3'd5, 32'd50,         32'd5,        5'd20, 32'd0,        0);
    add(K_NORM,  3'd7, 32'd100,        32'd7,        5'd21, 32'd2,        33); // flush cleared reuse
    add(K_NORM,  3'd5, 32'd100,        32'd7,        5'd22, 32'd14,       1);
    add(K_RST,   3'd0, 32'd9,          32'd9,        5'd23, 32'd0,        0);
    add(K_NORM,  3'd7, 32'd100,        32'd7,        5'd24, 32'd2,        33); // rst cleared reuse

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_wen", 64'(w_enable_o), 64'd0);
    chk("rst_waddr", 64'(w_addr_o), 64'd0);
    chk("rst_wdata", 64'(w_data_o), 64'd0);
    chk("rst_stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i]);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (any even value 8..64).
REQ-002 The block SHALL have parameter REUSE_EN, default 1, enabling the DIV/REM same-operand result reuse path.
REQ-003 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port valid_i, input, 1 bit: request present.
REQ-006 Port op_i, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Ports rs1_i and rs2_i, input, XLEN bits each: operands.
REQ-008 Port w_addr_i, input, 5 bits: destination register.
REQ-009 Port flush_i, input, 1 bit: abort the outstanding operation.
REQ-010 Port ready_o, output, 1 bit: block idle and able to accept a request.
REQ-011 Port done_o, output, 1 bit: one-cycle result strobe.
REQ-012 Ports w_enable_o (1 bit), w_addr_o (5 bits) and w_data_o (XLEN bits), outputs: write-back triple, valid while done_o=1.
REQ-013 Port stall_req_o, output, 1 bit: pipeline hold request.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; ready_o=1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge where state=IDLE and valid_i=1; op, operands and w_addr are captured on that edge.
REQ-016 Accepted MUL-family and normal DIV/REM operations SHALL iterate 1 bit per cycle for XLEN cycles in CALC, then enter DONE; done_o=1 exactly XLEN+1 cycles after the acceptance edge, for one cycle.
REQ-017 Signed operands SHALL be converted to magnitudes on accept, and the result negated on the CALC-to-DONE transition per RV32M sign rules; MULHSU treats rs1 as signed and rs2 as unsigned.
REQ-018 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2XLEN-1:XLEN].
REQ-019 Divide by zero SHALL bypass CALC: quotient all ones, remainder rs1; done_o one cycle after accept.
REQ-020 Signed overflow (DIV/REM of -2^(XLEN-1) by -1) SHALL bypass CALC: quotient rs1, remainder 0; done_o one cycle after accept.
REQ-021 With REUSE_EN=1, the block SHALL store the last completed quotient/remainder pair with its operands and signedness; a DIV/REM request matching all three SHALL complete one cycle after accept.
REQ-022 The reuse entry SHALL be invalidated by rst, flush_i and any completed MUL-family operation.
REQ-023 stall_req_o SHALL equal (valid_i & state=IDLE) | (state=CALC), combinationally; it is 0 in DONE.
REQ-024 DONE SHALL return to IDLE on the next edge; a new request in that IDLE cycle SHALL be accepted (one idle cycle minimum between operations).
REQ-025 A captured w_addr of 0 SHALL still complete with done_o=1, but with w_enable_o=0, w_addr_o=0 and w_data_o=0.
REQ-026 flush_i=1 in CALC or DONE SHALL force IDLE on the next edge with no done_o; flush_i in IDLE SHALL block acceptance that cycle.
REQ-027 When flush_i and done_o occur in the same cycle, the result SHALL be dropped and w_enable_o=0.

Reset
REQ-028 rst=1 SHALL, at the next edge, force IDLE, clear the reuse entry, and drive done_o, w_enable_o, w_addr_o and w_data_o to 0 with ready_o=1.
REQ-029 rst mid-CALC SHALL discard the operation with no done_o.

Structure
REQ-030 Op encodings, FSM state encoding and the iteration-counter width ($clog2(XLEN+1)) SHALL live in the shared package ex_muldiv_pkg.
REQ-031 The shift-add / restoring-subtract datapath SHALL be the sub-module muldiv_iter; ex_muldiv holds the FSM, sign handling, fast paths and reuse entry.

Verification (XLEN=32)
REQ-032 MUL 7 x 0xFFFFFFFD -> w_data 0xFFFFFFEB, done_o exactly 33 cycles after accept, stall_req_o high for cycles 0..32.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-034 DIV 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, each done_o one cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD in 33 cycles, then REM with the same operands -> 0xFFFFFFFF in 1 cycle; an intervening MUL forces 33 cycles.
REQ-036 flush_i at cycle 10 of a DIVU -> no done_o, ready_o=1 next cycle; rst at cycle 20 of a MUL -> all outputs 0 next cycle; w_addr_i=0 -> done_o=1, w_enable_o=0.
